// File: rtl/emotion_pkg.sv
// Shared types, per-axis defaults and saturation helper for the emotion regulators.
package emotion_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_N_STIM    = 7;
  localparam logic [6:0]  PLEASURE_INC_MASK = 7'b0000010;
  localparam logic [6:0]  PLEASURE_DEC_MASK = 7'b0000001;
  localparam int unsigned PLEASURE_THRESH   = 4;
  localparam logic [6:0]  AROUSAL_INC_MASK  = 7'b0000100;
  localparam logic [6:0]  AROUSAL_DEC_MASK  = 7'b0001000;
  localparam int unsigned AROUSAL_THRESH    = 4;

  // Clamp a signed value to the symmetric range +/-(2^(width-1)-1).
  function automatic int sat_signed(input int value, input int unsigned width);
    int lim;
    lim = (1 << (width - 1)) - 1;
    if (value > lim) begin
      return lim;
    end else if (value < -lim) begin
      return -lim;
    end
    return value;
  endfunction

endpackage

// File: rtl/emotion_regulator_stimulus_scorer.sv
// Combinational vote scorer: signed (increment votes - decrement votes).
module stimulus_scorer #(
  parameter int unsigned       N_STIM   = 7,
  parameter logic [N_STIM-1:0] INC_MASK = N_STIM'(7'b0000010),
  parameter logic [N_STIM-1:0] DEC_MASK = N_STIM'(7'b0000001),
  parameter int unsigned       DELTA_W  = $clog2(N_STIM + 2) + 1
) (
  input  logic [N_STIM-1:0]         i_stimuli,
  input  logic                      i_sleep_inc,
  input  logic                      i_sleep_dec,
  output logic signed [DELTA_W-1:0] o_delta_c
);

  localparam int unsigned CNT_W = DELTA_W - 1;

  logic [CNT_W-1:0] w_n_inc;
  logic [CNT_W-1:0] w_n_dec;

  // Popcount of masked stimuli plus the sleep-controller vote; a bit in both masks nets zero.
  always_comb begin
    w_n_inc = CNT_W'(i_sleep_inc);
    w_n_dec = CNT_W'(i_sleep_dec);
    for (int i = 0; i < int'(N_STIM); i++) begin
      w_n_inc = w_n_inc + CNT_W'(i_stimuli[i] & INC_MASK[i]);
      w_n_dec = w_n_dec + CNT_W'(i_stimuli[i] & DEC_MASK[i]);
    end
    o_delta_c = $signed({1'b0, w_n_inc}) - $signed({1'b0, w_n_dec});
  end

endmodule

// File: rtl/emotion_regulator.sv
// Clocked regulator: integrates stimulus votes, pulses inc/dec on threshold crossing, then cools down.
module emotion_regulator
  import emotion_pkg::*;
#(
  parameter int unsigned       N_STIM   = DEFAULT_N_STIM,
  parameter logic [N_STIM-1:0] INC_MASK = N_STIM'(PLEASURE_INC_MASK),
  parameter logic [N_STIM-1:0] DEC_MASK = N_STIM'(PLEASURE_DEC_MASK),
  parameter int unsigned       ACC_W    = 6,
  parameter int unsigned       THRESH   = PLEASURE_THRESH,
  parameter int unsigned       COOLDOWN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sleep_controller_inc,
  input  logic              sleep_controller_dec,
  input  logic [N_STIM-1:0] stimuli,
  output logic              pleasure_inc,
  output logic              pleasure_dec,
  output logic [ACC_W-1:0]  acc_level,
  output logic              busy
);

  localparam int unsigned DELTA_W = $clog2(N_STIM + 2) + 1;
  localparam int unsigned SUM_W   = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 1;
  localparam int unsigned CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [ACC_W-1:0] THR     = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] NEG_THR = -THR;

  state_t                    r_state;
  logic [CD_W-1:0]           r_cd;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_inc;
  logic                      r_dec;

  state_t                    w_state_nxt;
  logic [CD_W-1:0]           w_cd_nxt;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic                      w_inc_nxt;
  logic                      w_dec_nxt;
  logic signed [DELTA_W-1:0] w_delta;
  logic signed [SUM_W-1:0]   w_acc_sum;
  logic signed [ACC_W-1:0]   w_acc_sat;

  stimulus_scorer #(
    .N_STIM   (N_STIM),
    .INC_MASK (INC_MASK),
    .DEC_MASK (DEC_MASK),
    .DELTA_W  (DELTA_W)
  ) u_scorer (
    .i_stimuli   (stimuli),
    .i_sleep_inc (sleep_controller_inc),
    .i_sleep_dec (sleep_controller_dec),
    .o_delta_c   (w_delta)
  );

  // Full-width sum then symmetric saturation so the accumulator never wraps.
  always_comb begin
    w_acc_sum = SUM_W'(r_acc) + SUM_W'(w_delta);
    w_acc_sat = ACC_W'(sat_signed(int'(w_acc_sum), ACC_W));
  end

  // Next-state, accumulator and pulse decode; everything holds while disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_acc_nxt   = r_acc;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc_sat >= THR) begin
            w_inc_nxt = 1'b1;
            w_acc_nxt = w_acc_sat - THR;
            if (COOLDOWN > 0) begin
              w_state_nxt = ST_COOLDOWN;
              w_cd_nxt    = CD_W'(COOLDOWN);
            end
          end else if (w_acc_sat <= NEG_THR) begin
            w_dec_nxt = 1'b1;
            w_acc_nxt = w_acc_sat + THR;
            if (COOLDOWN > 0) begin
              w_state_nxt = ST_COOLDOWN;
              w_cd_nxt    = CD_W'(COOLDOWN);
            end
          end else begin
            w_acc_nxt = w_acc_sat;
          end
        end
        ST_COOLDOWN: begin
          w_acc_nxt = w_acc_sat;
          if (r_cd <= CD_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cd_nxt    = '0;
          end else begin
            w_cd_nxt = r_cd - CD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cd_nxt    = '0;
        end
      endcase
    end
  end

  // State, counter, accumulator and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
      r_acc   <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_acc   <= w_acc_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  assign pleasure_inc = r_inc;
  assign pleasure_dec = r_dec;
  assign acc_level    = r_acc;
  assign busy         = (r_state == ST_COOLDOWN);

endmodule

// File: tb/tb_emotion_regulator.sv
// Directed bench: default instance (a) plus a long-cooldown instance (b) for saturation.
module tb_emotion_regulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sl_inc;
  logic       sl_dec;
  logic [6:0] stimuli;

  logic       inc_a, dec_a, busy_a;
  logic [5:0] acc_a;
  logic       inc_b, dec_b, busy_b;
  logic [5:0] acc_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  emotion_regulator u_a (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .sleep_controller_inc (sl_inc),
    .sleep_controller_dec (sl_dec),
    .stimuli              (stimuli),
    .pleasure_inc         (inc_a),
    .pleasure_dec         (dec_a),
    .acc_level            (acc_a),
    .busy                 (busy_a)
  );

  emotion_regulator #(.COOLDOWN(40)) u_b (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .sleep_controller_inc (sl_inc),
    .sleep_controller_dec (sl_dec),
    .stimuli              (stimuli),
    .pleasure_inc         (inc_b),
    .pleasure_dec         (dec_b),
    .acc_level            (acc_b),
    .busy                 (busy_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input int acc, input int inc, input int dec, input int bsy);
    chk({tag, "_acc"},  $signed(acc_a), acc);
    chk({tag, "_inc"},  inc_a, inc);
    chk({tag, "_dec"},  dec_a, dec);
    chk({tag, "_busy"}, busy_a, bsy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int found;
    int exp;
    rst     = 1'b1;
    enable  = 1'b1;
    sl_inc  = 1'b0;
    sl_dec  = 1'b0;
    stimuli = 7'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("por", 0, 0, 0, 0);
    rst = 1'b0;

    // Held increment stimulus: ramp, pulse, cooldown, period 4.
    stimuli = 7'b0000010;
    step(); chk_a("s2_e1", 1, 0, 0, 0);
    step(); chk_a("s2_e2", 2, 0, 0, 0);
    step(); chk_a("s2_e3", 3, 0, 0, 0);
    step(); chk_a("s2_e4", 0, 1, 0, 1);
    step(); chk_a("s2_e5", 1, 0, 0, 1);
    step(); chk_a("s2_e6", 2, 0, 0, 1);
    step(); chk_a("s2_e7", 3, 0, 0, 0);
    step(); chk_a("s2_e8", 0, 1, 0, 1);
    step(); chk_a("s2_e9", 1, 0, 0, 1);

    // Asynchronous reset mid-cycle, mid-cooldown.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Opposing votes cancel.
    stimuli = 7'b0000011;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("s3_acc", $signed(acc_a), 0);
      chk("s3_pulses", {inc_a, dec_a}, 0);
    end

    // Saturation on the long-cooldown instance.
    do_reset();
    stimuli = 7'b0000001;
    sl_dec  = 1'b1;
    step(); chk("s4_e1_acc", $signed(acc_b), -2);
    step(); chk("s4_e2_dec", dec_b, 1);
    chk("s4_e2_acc", $signed(acc_b), 0);
    chk("s4_e2_busy", busy_b, 1);
    for (int k = 3; k <= 25; k++) begin
      step();
      exp = -2 * (k - 2);
      if (exp < -31) exp = -31;
      chk("s4_ramp_acc", $signed(acc_b), exp);
      chk("s4_ramp_pulses", {inc_b, dec_b}, 0);
    end
    stimuli = 7'b0;
    sl_dec  = 1'b0;
    cnt   = 0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cnt++;
      if (busy_b == 1'b0) begin
        found = 1;
        break;
      end
      chk("s4_hold_acc", $signed(acc_b), -31);
      chk("s4_hold_pulses", {inc_b, dec_b}, 0);
    end
    chk("s4_cd_expired", found, 1);
    chk("s4_cd_len", cnt, 17);
    step();
    chk("s4_post_dec", dec_b, 1);
    chk("s4_post_inc", inc_b, 0);
    chk("s4_post_acc", $signed(acc_b), -27);

    // Sleep-controller-only increment path.
    do_reset();
    sl_inc = 1'b1;
    step(); chk_a("s5_e1", 1, 0, 0, 0);
    step(); chk_a("s5_e2", 2, 0, 0, 0);
    step(); chk_a("s5_e3", 3, 0, 0, 0);
    step(); chk_a("s5_e4", 0, 1, 0, 1);
    sl_inc = 1'b0;

    // Enable freeze at acc = 2, then resume.
    do_reset();
    stimuli = 7'b0000010;
    step(); step();
    chk_a("s6_pre", 2, 0, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("s6_frozen", 2, 0, 0, 0);
    end
    enable = 1'b1;
    step(); chk_a("s6_r1", 3, 0, 0, 0);
    step(); chk_a("s6_r2", 0, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
